// File: rtl/shot_command_parser.sv
// shot_command_parser: PS/2 set-2 make codes -> letter/number shot command.
// Optional turn-forfeit timer is built only when TURN_TIMEOUT_EN is defined.
module shot_command_parser #(
   parameter int TIMEOUT_CYCLES = 810_000_000,
   parameter int TIMEOUT_W      = 30
) (
   input  logic       clock27,
   input  logic       reset,
   input  logic [7:0] key_data,
   input  logic       key_valid,
   input  logic       cmd_ready,
   output logic [3:0] letter,
   output logic [3:0] number,
   output logic       cmd_valid,
   output logic       playerTurn,
   output logic       key_error,
   output logic [1:0] entry_state,
   output logic       turn_timeout
);

   localparam logic [1:0] S_LETTER  = 2'b00;
   localparam logic [1:0] S_NUMBER  = 2'b01;
   localparam logic [1:0] S_CONFIRM = 2'b10;
   localparam logic [1:0] S_ISSUE   = 2'b11;

   localparam logic [TIMEOUT_W-1:0] CNT_MAX =
      TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   logic       brk;
   logic       ext;
   logic       is_prefix;
   logic       make;
   logic       is_let;
   logic       is_dig;
   logic       is_ent;
   logic       is_bsp;
   logic [3:0] let_val;
   logic [3:0] dig_val;
   logic [1:0] state;
   logic [1:0] state_nx;
   logic [3:0] letter_nx;
   logic [3:0] number_nx;
   logic       err_nx;
   logic       legal;
   logic       toggle;
   logic       expire;

   assign is_prefix = (key_data == 8'hF0) || (key_data == 8'hE0);
   assign make = key_valid && !is_prefix && !brk && !ext;
   assign entry_state = state;

   // Break/extended prefix flags; the byte after a prefix is swallowed.
   always_ff @(posedge clock27) begin
      if (reset) begin
         brk <= 1'b0;
         ext <= 1'b0;
      end else if (key_valid) begin
         if (key_data == 8'hF0) begin
            brk <= 1'b1;
         end else if (key_data == 8'hE0) begin
            ext <= 1'b1;
         end else begin
            brk <= 1'b0;
            ext <= 1'b0;
         end
      end
   end

   // Scan-code classification into letter, digit, Enter, Backspace.
   always_comb begin
      is_let  = 1'b0;
      is_dig  = 1'b0;
      is_ent  = 1'b0;
      is_bsp  = 1'b0;
      let_val = 4'd0;
      dig_val = 4'd0;
      unique case (key_data)
         8'h1C: begin is_let = 1'b1; let_val = 4'd0; end
         8'h32: begin is_let = 1'b1; let_val = 4'd1; end
         8'h21: begin is_let = 1'b1; let_val = 4'd2; end
         8'h23: begin is_let = 1'b1; let_val = 4'd3; end
         8'h24: begin is_let = 1'b1; let_val = 4'd4; end
         8'h2B: begin is_let = 1'b1; let_val = 4'd5; end
         8'h34: begin is_let = 1'b1; let_val = 4'd6; end
         8'h33: begin is_let = 1'b1; let_val = 4'd7; end
         8'h43: begin is_let = 1'b1; let_val = 4'd8; end
         8'h3B: begin is_let = 1'b1; let_val = 4'd9; end
         8'h45: begin is_dig = 1'b1; dig_val = 4'd0; end
         8'h16: begin is_dig = 1'b1; dig_val = 4'd1; end
         8'h1E: begin is_dig = 1'b1; dig_val = 4'd2; end
         8'h26: begin is_dig = 1'b1; dig_val = 4'd3; end
         8'h25: begin is_dig = 1'b1; dig_val = 4'd4; end
         8'h2E: begin is_dig = 1'b1; dig_val = 4'd5; end
         8'h36: begin is_dig = 1'b1; dig_val = 4'd6; end
         8'h3D: begin is_dig = 1'b1; dig_val = 4'd7; end
         8'h3E: begin is_dig = 1'b1; dig_val = 4'd8; end
         8'h46: begin is_dig = 1'b1; dig_val = 4'd9; end
         8'h5A: is_ent = 1'b1;
         8'h66: is_bsp = 1'b1;
         default: ;
      endcase
   end

   // Entry FSM next-state; a forfeit overrides any key in the same cycle.
   always_comb begin
      state_nx  = state;
      letter_nx = letter;
      number_nx = number;
      err_nx    = 1'b0;
      legal     = 1'b0;
      toggle    = 1'b0;
      unique case (state)
         S_LETTER: begin
            if (make && is_let) begin
               letter_nx = let_val;
               state_nx  = S_NUMBER;
               legal     = 1'b1;
            end else if (make && (is_dig || is_ent || is_bsp)) begin
               err_nx = 1'b1;
            end
         end
         S_NUMBER: begin
            if (make && is_dig) begin
               number_nx = dig_val;
               state_nx  = S_CONFIRM;
               legal     = 1'b1;
            end else if (make && is_bsp) begin
               state_nx = S_LETTER;
               legal    = 1'b1;
            end else if (make && (is_let || is_ent)) begin
               err_nx = 1'b1;
            end
         end
         S_CONFIRM: begin
            if (make && is_ent) begin
               state_nx = S_ISSUE;
               legal    = 1'b1;
            end else if (make && is_let) begin
               letter_nx = let_val;
               legal     = 1'b1;
            end else if (make && is_dig) begin
               number_nx = dig_val;
               legal     = 1'b1;
            end else if (make && is_bsp) begin
               state_nx = S_NUMBER;
               legal    = 1'b1;
            end
         end
         default: begin
            if (cmd_ready) begin
               state_nx = S_LETTER;
               toggle   = 1'b1;
            end
         end
      endcase
      if (expire) begin
         state_nx  = S_LETTER;
         letter_nx = 4'd0;
         number_nx = 4'd0;
         err_nx    = 1'b0;
         legal     = 1'b0;
         toggle    = 1'b1;
      end
   end

   // Registered state, fields, handshake and turn ownership.
   always_ff @(posedge clock27) begin
      if (reset) begin
         state      <= S_LETTER;
         letter     <= 4'd0;
         number     <= 4'd0;
         key_error  <= 1'b0;
         cmd_valid  <= 1'b0;
         playerTurn <= 1'b0;
      end else begin
         state     <= state_nx;
         letter    <= letter_nx;
         number    <= number_nx;
         key_error <= err_nx;
         cmd_valid <= (state_nx == S_ISSUE);
         if (toggle) begin
            playerTurn <= ~playerTurn;
         end
      end
   end

`ifdef TURN_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] cnt;
   logic                 to_letter;

   assign expire    = (state != S_ISSUE) && (cnt == CNT_MAX);
   assign to_letter = (state_nx == S_LETTER) && (state != S_LETTER);

   // Idle counter: runs while entering, frozen while the shot waits.
   always_ff @(posedge clock27) begin
      if (reset || expire || legal || to_letter) begin
         cnt <= '0;
      end else if (state != S_ISSUE) begin
         cnt <= cnt + 1'b1;
      end
   end

   // One-cycle forfeit pulse.
   always_ff @(posedge clock27) begin
      if (reset) begin
         turn_timeout <= 1'b0;
      end else begin
         turn_timeout <= expire;
      end
   end
`else
   logic unused_cfg;

   assign expire       = 1'b0;
   assign turn_timeout = 1'b0;
   assign unused_cfg   = ^{CNT_MAX, legal};
`endif

endmodule

// File: tb/tb_shot_command_parser.sv
// tb_shot_command_parser: directed key sequences, queued expected shots.
// Build with TURN_TIMEOUT_EN to exercise the forfeit timer (16 cycles).
module tb_shot_command_parser;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] key_data;
   logic       key_valid;
   logic       cmd_ready;
   logic [3:0] letter;
   logic [3:0] number;
   logic       cmd_valid;
   logic       playerTurn;
   logic       key_error;
   logic [1:0] entry_state;
   logic       turn_timeout;

   typedef struct {
      int let_e;
      int num_e;
      int turn_e;
   } shot_t;

   shot_t exp_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   int    err_cnt = 0;
   int    to_cnt = 0;
   int    acc_cnt = 0;
   int    exp_turn = 0;
   logic  cv_q = 1'b0;

   shot_command_parser #(
      .TIMEOUT_CYCLES(16),
      .TIMEOUT_W(5)
   ) dut (
      .clock27(clk),
      .reset(reset),
      .key_data(key_data),
      .key_valid(key_valid),
      .cmd_ready(cmd_ready),
      .letter(letter),
      .number(number),
      .cmd_valid(cmd_valid),
      .playerTurn(playerTurn),
      .key_error(key_error),
      .entry_state(entry_state),
      .turn_timeout(turn_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [7:0] b);
      key_data  = b;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic accept();
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      exp_turn  = 1 - exp_turn;
   endtask

   task automatic push(input int l, input int n);
      shot_t s;
      s.let_e  = l;
      s.num_e  = n;
      s.turn_e = exp_turn;
      exp_q.push_back(s);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_turn = 0;
   endtask

   // Monitor: checks each newly presented shot against the queue.
   always @(negedge clk) begin
      shot_t e;
      if (!reset) begin
         if (cmd_valid && !cv_q) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_cmd", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("shot_letter", 32'(letter), 32'(e.let_e));
               chk("shot_number", 32'(number), 32'(e.num_e));
               chk("shot_turn", 32'(playerTurn), 32'(e.turn_e));
            end
         end
         if (cmd_valid && cmd_ready) acc_cnt++;
         if (key_error) err_cnt++;
         if (turn_timeout) to_cnt++;
      end
      cv_q = cmd_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      key_data  = 8'h00;
      key_valid = 1'b0;
      cmd_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_letter", 32'(letter), 32'd0);
      chk("rst_number", 32'(number), 32'd0);
      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_turn", 32'(playerTurn), 32'd0);
      chk("rst_err", 32'(key_error), 32'd0);
      chk("rst_state", 32'(entry_state), 32'd0);
      chk("rst_timeout", 32'(turn_timeout), 32'd0);

      // Basic shot E3 with break codes interleaved
      key(8'h24); key(8'hF0); key(8'h24);
      key(8'h26); key(8'hF0); key(8'h26);
      push(4, 3);
      key(8'h5A);
      chk("basic_state", 32'(entry_state), 32'd3);
      chk("basic_valid", 32'(cmd_valid), 32'd1);
      repeat (20) tick();
      chk("hold_valid", 32'(cmd_valid), 32'd1);
      chk("hold_letter", 32'(letter), 32'd4);
      chk("hold_number", 32'(number), 32'd3);
      accept();
      chk("acc_valid", 32'(cmd_valid), 32'd0);
      chk("acc_turn", 32'(playerTurn), 32'd1);
      chk("acc_state", 32'(entry_state), 32'd0);

      // Digit in LETTER is an error; backspace path; J0 shot
      key(8'h16);
      chk("err_pulse", 32'(key_error), 32'd1);
      chk("err_state", 32'(entry_state), 32'd0);
      tick();
      chk("err_clear", 32'(key_error), 32'd0);
      key(8'h1C);
      key(8'h66);
      chk("bsp_state", 32'(entry_state), 32'd0);
      key(8'h3B);
      key(8'h45);
      push(9, 0);
      key(8'h5A);
      chk("j0_valid", 32'(cmd_valid), 32'd1);
      chk("j0_letter", 32'(letter), 32'd9);
      chk("j0_number", 32'(number), 32'd0);
      accept();
      chk("j0_turn", 32'(playerTurn), 32'd0);

      // Enter in NUMBER is an error
      key(8'h1C);
      key(8'h5A);
      chk("ent_num_err", 32'(key_error), 32'd1);
      chk("ent_num_state", 32'(entry_state), 32'd1);
      key(8'h66);

      // Overwrite, extended Enter discarded, key during acceptance
      key(8'h1C); key(8'h16); key(8'h1E);
      chk("ovr_number", 32'(number), 32'd2);
      key(8'hE0); key(8'h5A);
      chk("ext_state", 32'(entry_state), 32'd2);
      chk("ext_err", 32'(key_error), 32'd0);
      push(0, 2);
      key(8'h5A);
      chk("ovr_state", 32'(entry_state), 32'd3);
      key_data  = 8'h3B;
      key_valid = 1'b1;
      cmd_ready = 1'b1;
      tick();
      key_valid = 1'b0;
      cmd_ready = 1'b0;
      exp_turn  = 1 - exp_turn;
      chk("race_state", 32'(entry_state), 32'd0);
      chk("race_err", 32'(key_error), 32'd0);
      chk("race_valid", 32'(cmd_valid), 32'd0);
      chk("race_turn", 32'(playerTurn), 32'd1);
      chk("race_letter", 32'(letter), 32'd0);

      // Reset in CONFIRM
      key(8'h21); key(8'h16);
      do_reset();
      chk("rc_state", 32'(entry_state), 32'd0);
      chk("rc_letter", 32'(letter), 32'd0);
      chk("rc_number", 32'(number), 32'd0);
      chk("rc_turn", 32'(playerTurn), 32'd0);

      // Reset in ISSUE
      key(8'h21); key(8'h16);
      push(2, 1);
      key(8'h5A);
      tick();
      do_reset();
      chk("ri_valid", 32'(cmd_valid), 32'd0);
      chk("ri_state", 32'(entry_state), 32'd0);
      chk("ri_turn", 32'(playerTurn), 32'd0);

`ifdef TURN_TIMEOUT_EN
      // Idle forfeit after 16 cycles
      key(8'h3B);
      repeat (15) tick();
      chk("pre_to", 32'(turn_timeout), 32'd0);
      chk("pre_to_state", 32'(entry_state), 32'd1);
      tick();
      exp_turn = 1 - exp_turn;
      chk("to_pulse", 32'(turn_timeout), 32'd1);
      chk("to_turn", 32'(playerTurn), 32'd1);
      chk("to_letter", 32'(letter), 32'd0);
      chk("to_state", 32'(entry_state), 32'd0);
      // Legal key every 10 cycles keeps the turn alive
      key(8'h3B);
      for (int i = 0; i < 5; i++) begin
         repeat (9) tick();
         key(8'h16);
      end
      chk("keep_state", 32'(entry_state), 32'd2);
      push(9, 1);
      key(8'h5A);
      repeat (40) tick();
      chk("issue_hold", 32'(cmd_valid), 32'd1);
      accept();
      chk("to_count", 32'(to_cnt), 32'd1);
      chk("acc_count", 32'(acc_cnt), 32'd4);
`else
      chk("to_count", 32'(to_cnt), 32'd0);
      chk("acc_count", 32'(acc_cnt), 32'd3);
`endif
      tick();
      chk("err_count", 32'(err_cnt), 32'd2);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
